// File: rtl/lstm_gate_mac.sv
// LSTM gate neuron: a = f(sum(k_i*w_i) + b), time-multiplexed over LANES multipliers.
// Owns its weight/bias register file; hard-sigmoid or hard-tanh selected per evaluation.
module lstm_gate_mac #(
    parameter int NUM   = 76,
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int LANES = 4,
    parameter int AW    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_mode,
    input  logic [NUM*WIDTH-1:0]   i_k,
    input  logic                   i_wr,
    input  logic [AW-1:0]          i_waddr,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_a,
    output logic [WIDTH-1:0]       o_sum,
    output logic [NUM*WIDTH-1:0]   o_w,
    output logic [WIDTH-1:0]       o_b,
    output logic                   o_werr
);

    localparam int C   = (NUM + LANES - 1) / LANES;
    localparam int PAD = C * LANES;
    localparam int CW  = (C > 1) ? $clog2(C) : 1;
    localparam int DW  = 2 * WIDTH;
    localparam int EW  = WIDTH + 2;

    localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM);
    localparam logic [CW-1:0] LAST_CNT  = CW'(C - 1);

    localparam logic signed [DW-1:0] SAT_HI = {{(DW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_LO = {{(DW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    localparam logic signed [EW-1:0] ONE     = EW'(1) << FRAC;
    localparam logic signed [EW-1:0] HALF    = EW'(1) << (FRAC - 1);
    localparam logic signed [EW-1:0] NEG_ONE = -ONE;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ACT
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    mode_q;
    logic [NUM*WIDTH-1:0]    k_q;
    logic signed [WIDTH-1:0] w_mem [NUM];
    logic signed [WIDTH-1:0] bias;
    logic signed [DW-1:0]    acc;

    // Operands padded to a whole number of lane groups; the tail lanes read zero.
    logic signed [WIDTH-1:0] k_pad [PAD];
    logic signed [WIDTH-1:0] w_pad [PAD];

    for (genvar i = 0; i < PAD; i++) begin : g_pad
        if (i < NUM) begin : g_real
            assign k_pad[i] = k_q[i*WIDTH +: WIDTH];
            assign w_pad[i] = w_mem[i];
        end else begin : g_zero
            assign k_pad[i] = '0;
            assign w_pad[i] = '0;
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_wtap
        assign o_w[i*WIDTH +: WIDTH] = w_mem[i];
    end
    assign o_b = bias;

    logic signed [WIDTH-1:0] k_lane [LANES];
    logic signed [WIDTH-1:0] w_lane [LANES];
    logic signed [DW-1:0]    prod   [LANES];
    logic signed [DW-1:0]    mac_sum;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mac_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            k_lane[l] = '0;
            w_lane[l] = '0;
            for (int j = 0; j < C; j++) begin
                if (cnt == CW'(j)) begin
                    k_lane[l] = k_pad[j*LANES + l];
                    w_lane[l] = w_pad[j*LANES + l];
                end
            end
            prod[l] = DW'(k_lane[l]) * DW'(w_lane[l]);
            mac_sum = mac_sum + (prod[l] >>> FRAC);
        end
    end

    logic signed [WIDTH-1:0] sat_x;

    always_comb begin
        if (acc > SAT_HI) begin
            sat_x = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (acc < SAT_LO) begin
            sat_x = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_x = acc[WIDTH-1:0];
        end
    end

    // Activation is evaluated at EW bits so the +one/2 offset cannot wrap.
    logic signed [EW-1:0]    x_e;
    logic signed [EW-1:0]    sig_t;
    logic signed [EW-1:0]    act_e;
    logic signed [WIDTH-1:0] act_x;

    always_comb begin
        x_e   = EW'(sat_x);
        sig_t = (x_e >>> 2) + HALF;
        act_e = x_e;
        if (mode_q) begin
            if (x_e > ONE) begin
                act_e = ONE;
            end else if (x_e < NEG_ONE) begin
                act_e = NEG_ONE;
            end
        end else begin
            if (sig_t > ONE) begin
                act_e = ONE;
            end else if (sig_t[EW-1]) begin
                act_e = '0;
            end else begin
                act_e = sig_t;
            end
        end
        act_x = act_e[WIDTH-1:0];
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            bias    <= '0;
            acc     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_werr  <= 1'b0;
            o_a     <= '0;
            o_sum   <= '0;
            // NOTE: the register file is plain flops and must read back zero after reset.
            for (int i = 0; i < NUM; i++) begin
                w_mem[i] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            o_werr  <= 1'b0;

            if (i_wr) begin
                if (state != IDLE || i_waddr > BIAS_ADDR) begin
                    o_werr <= 1'b1;
                end else if (i_waddr == BIAS_ADDR) begin
                    bias <= i_wdata;
                end else begin
                    for (int i = 0; i < NUM; i++) begin
                        if (i_waddr == AW'(i)) begin
                            w_mem[i] <= i_wdata;
                        end
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        k_q    <= i_k;
                        mode_q <= i_mode;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= MAC;
                        // A bias written in the start cycle is already the one used.
                        acc    <= (i_wr && i_waddr == BIAS_ADDR) ? DW'(signed'(i_wdata))
                                                                 : DW'(bias);
                    end
                end
                MAC: begin
                    acc <= acc + mac_sum;
                    if (cnt == LAST_CNT) begin
                        state <= ACT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACT: begin
                    o_sum   <= sat_x;
                    o_a     <= act_x;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Scoreboard bench for lstm_gate_mac at NUM=5, LANES=2, WIDTH=16, FRAC=8 (three MAC cycles).
module tb_lstm_gate_mac;

    localparam int NUM   = 5;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 2;
    localparam int AW    = 3;
    localparam int C     = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_mode = 1'b0;
    logic [NUM*WIDTH-1:0] i_k = '0;
    logic                 i_wr = 1'b0;
    logic [AW-1:0]        i_waddr = '0;
    logic [WIDTH-1:0]     i_wdata = '0;
    logic                 o_busy;
    logic                 o_valid;
    logic [WIDTH-1:0]     o_a;
    logic [WIDTH-1:0]     o_sum;
    logic [NUM*WIDTH-1:0] o_w;
    logic [WIDTH-1:0]     o_b;
    logic                 o_werr;

    lstm_gate_mac #(
        .NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_k(i_k),
        .i_wr(i_wr), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_valid(o_valid), .o_a(o_a), .o_sum(o_sum),
        .o_w(o_w), .o_b(o_b), .o_werr(o_werr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest expected result, on its cycle.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", o_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_sum"}, o_sum, mon_e.sum);
                check({mon_e.name, "_a"}, o_a, mon_e.a);
                check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [NUM*WIDTH-1:0] kall(input logic [WIDTH-1:0] v);
        return {NUM{v}};
    endfunction

    task automatic write_word(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        i_wr    = 1'b1;
        i_waddr = addr;
        i_wdata = data;
        @(negedge clk);
        i_wr    = 1'b0;
    endtask

    task automatic write_all_w(input logic [WIDTH-1:0] v);
        for (int i = 0; i < NUM; i++) write_word(AW'(i), v);
    endtask

    task automatic start_op(input string name, input logic mode, input logic [NUM*WIDTH-1:0] k,
                            input logic [WIDTH-1:0] es, input logic [WIDTH-1:0] ea);
        i_start = 1'b1;
        i_mode  = mode;
        i_k     = k;
        @(negedge clk);
        i_start = 1'b0;
        sb.push_back('{name: name, sum: es, a: ea, cyc: cyc + C + 1});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        check({name, "_idle"}, o_busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_werr", o_werr, 1'b0);
        check("rst_a", o_a, 16'h0000);
        check("rst_sum", o_sum, 16'h0000);
        check("rst_w", o_w, '0);
        check("rst_b", o_b, 16'h0000);

        // Register file write and readback.
        write_all_w(16'h0020);
        check("wr_w_werr", o_werr, 1'b0);
        write_word(AW'(5), 16'h0040);
        check("wr_b_werr", o_werr, 1'b0);
        check("wr_w", o_w, {NUM{16'h0020}});
        check("wr_b", o_b, 16'h0040);

        // Nominal: 5*0.125 + 0.25 = 0.875.
        start_op("nom_tanh", 1'b1, kall(16'h0100), 16'h00E0, 16'h00E0);
        drain("nom_tanh");
        start_op("nom_sig", 1'b0, kall(16'h0100), 16'h00E0, 16'h00B8);
        drain("nom_sig");
        // Mixed signs: 0.125 - 0.125 + 0.25 + 0 - 0.0625 + 0.25 = 0.4375.
        start_op("mixed_sig", 1'b0, {16'hFF80, 16'h0000, 16'h0200, 16'hFF00, 16'h0100},
                 16'h0070, 16'h009C);
        drain("mixed_sig");

        // Start and write while busy are both ignored.
        start_op("busy_op", 1'b1, kall(16'h0100), 16'h00E0, 16'h00E0);
        i_start = 1'b1;
        i_wr    = 1'b1;
        i_waddr = '0;
        i_wdata = 16'h1234;
        @(negedge clk);
        i_wr = 1'b0;
        check("busy_werr", o_werr, 1'b1);
        check("busy_w_kept", o_w, {NUM{16'h0020}});
        check("busy_flag", o_busy, 1'b1);
        @(negedge clk);
        i_start = 1'b0;
        check("busy_werr_pulse", o_werr, 1'b0);
        drain("busy");
        repeat (8) @(negedge clk);
        check("busy_single_op", o_busy, 1'b0);

        // Addresses above the bias slot are dropped.
        write_word(AW'(6), 16'h5555);
        check("addr6_werr", o_werr, 1'b1);
        check("addr6_w_kept", o_w, {NUM{16'h0020}});
        check("addr6_b_kept", o_b, 16'h0040);
        write_word(AW'(7), 16'h5555);
        check("addr7_werr", o_werr, 1'b1);

        // Writes in the start cycle feed the same evaluation.
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_k     = kall(16'h0100);
        i_wr    = 1'b1;
        i_waddr = AW'(5);
        i_wdata = 16'h0000;
        @(negedge clk);
        i_start = 1'b0;
        i_wr    = 1'b0;
        sb.push_back('{name: "wr_bias_start", sum: 16'h00A0, a: 16'h00A0, cyc: cyc + C + 1});
        check("wr_bias_start_werr", o_werr, 1'b0);
        check("wr_bias_start_b", o_b, 16'h0000);
        drain("wr_bias_start");
        i_start = 1'b1;
        i_wr    = 1'b1;
        i_waddr = AW'(0);
        i_wdata = 16'h0040;
        @(negedge clk);
        i_start = 1'b0;
        i_wr    = 1'b0;
        sb.push_back('{name: "wr_w0_start", sum: 16'h00C0, a: 16'h00C0, cyc: cyc + C + 1});
        drain("wr_w0_start");

        // Products truncate toward -inf: -0.5 * (1/256) -> -1 LSB each.
        write_all_w(16'h0001);
        start_op("trunc_sig", 1'b0, kall(16'hFF80), 16'hFFFB, 16'h007E);
        drain("trunc_sig");
        start_op("trunc_tanh", 1'b1, kall(16'hFF80), 16'hFFFB, 16'hFFFB);
        drain("trunc_tanh");

        // Saturation in both directions.
        write_all_w(16'h7FFF);
        start_op("satp_sig", 1'b0, kall(16'h7FFF), 16'h7FFF, 16'h0100);
        drain("satp_sig");
        start_op("satp_tanh", 1'b1, kall(16'h7FFF), 16'h7FFF, 16'h0100);
        drain("satp_tanh");
        write_all_w(16'h8000);
        start_op("satn_sig", 1'b0, kall(16'h7FFF), 16'h8000, 16'h0000);
        drain("satn_sig");
        start_op("satn_tanh", 1'b1, kall(16'h7FFF), 16'h8000, 16'hFF00);
        drain("satn_tanh");

        // Back-to-back: restart in the o_valid cycle.
        start_op("b2b_first", 1'b1, kall(16'h7FFF), 16'h8000, 16'hFF00);
        n = 0;
        while (o_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_seen", o_valid, 1'b1);
        i_start = 1'b1;
        i_mode  = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        sb.push_back('{name: "b2b_second", sum: 16'h8000, a: 16'h0000, cyc: cyc + C + 1});
        check("b2b_busy", o_busy, 1'b1);
        drain("b2b");

        // Reset in the middle of MAC aborts without a result.
        i_start = 1'b1;
        i_mode  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_valid", o_valid, 1'b0);
        check("abort_w", o_w, '0);
        check("abort_b", o_b, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_valid_busy", o_busy, 1'b0);
        start_op("post_rst_sig", 1'b0, kall(16'h0100), 16'h0000, 16'h0080);
        drain("post_rst_sig");
        start_op("post_rst_tanh", 1'b1, kall(16'h0100), 16'h0000, 16'h0000);
        drain("post_rst_tanh");

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
